// File: rtl/servo_pkg.sv
// servo_pkg: definitions shared by the servo setpoint ramp and the PID/PWM top.
// Holds the ramp FSM state encoding, the default rk clamp window and a
// saturation helper used when the optional clamp is built in.
package servo_pkg;

  // Ramp FSM states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } ramp_state_e;

  // Default setpoint window shared with the PID top.
  localparam int RK_MIN_DEF = -100;
  localparam int RK_MAX_DEF = 100;

  // Saturate a signed value into [lo, hi].
  function automatic int sat_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler. Counts 0..TICK_DIV-1 and raises tick
// for the single cycle in which the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == CW'(TICK_DIV - 1));

  // Next count: wrap to zero after the terminal value.
  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // Count register, cleared asynchronously.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/setpoint_ramp.sv
// setpoint_ramp: slew-rate limiter for the servo position setpoint.
// A load strobe latches a signed target; rk then moves toward it by STEP
// counts on every prescaler tick and stops exactly on the target.
// Optional build macro: SETPOINT_RAMP_LIMIT_EN saturates the target into
// [RK_MIN, RK_MAX] before latching; without it the full signed range is used.
module setpoint_ramp
  import servo_pkg::*;
#(
  parameter int Width    = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 1,
  parameter int RK_MIN   = RK_MIN_DEF,
  parameter int RK_MAX   = RK_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [Width-1:0] target,
  input  logic                    load,
  output logic signed [Width-1:0] rk,
  output logic                    busy,
  output logic                    done
);

  // Reject configurations the stepper cannot honour.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("setpoint_ramp: TICK_DIV must be >= 2");
  end
  if (STEP < 1 || STEP >= (1 << (Width - 1))) begin : g_bad_step
    $error("setpoint_ramp: STEP out of range");
  end
  if (RK_MIN > RK_MAX) begin : g_bad_window
    $error("setpoint_ramp: RK_MIN must not exceed RK_MAX");
  end

  localparam logic [Width:0]        STEP_W  = (Width + 1)'(STEP);
  localparam logic signed [Width-1:0] STEP_RK = Width'(STEP);

  logic                    tick;
  logic signed [Width-1:0] tgt_in;
  logic signed [Width-1:0] tgt_q, tgt_d;
  logic signed [Width-1:0] rk_q, rk_d;
  ramp_state_e             state_q, state_d;
  logic                    busy_q;
  logic                    done_q, done_d;
  logic signed [Width:0]   diff;
  logic [Width:0]          mag;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

`ifdef SETPOINT_RAMP_LIMIT_EN
  // Saturate the request into the allowed window before it is latched.
  always_comb begin
    tgt_in = Width'(sat_int(int'(target), RK_MIN, RK_MAX));
  end
`else
  // Request is latched unmodified; the full signed range is legal.
  always_comb begin
    tgt_in = target;
  end
`endif

  // Target latch: load is honoured in every state.
  always_comb begin
    tgt_d = load ? tgt_in : tgt_q;
  end

  // Stepper: one extra bit keeps tgt-rk exact even for a full-range swing,
  // and a remaining distance of STEP or less lands exactly on the target.
  // Direction follows the sign of the distance, so a re-target between
  // ticks never steps the wrong way while the FSM is catching up.
  always_comb begin
    diff = (Width + 1)'(tgt_q) - (Width + 1)'(rk_q);
    mag  = diff[Width] ? (Width + 1)'(-diff) : (Width + 1)'(diff);
    rk_d = rk_q;
    if (tick && (state_q != ST_IDLE)) begin
      if (diff > 0) begin
        rk_d = (mag <= STEP_W) ? tgt_q : rk_q + STEP_RK;
      end else if (diff < 0) begin
        rk_d = (mag <= STEP_W) ? tgt_q : rk_q - STEP_RK;
      end
    end
  end

  // FSM next state and done pulse, evaluated from the latched target vs rk.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          // Direction is decided next cycle from the new target; a target
          // already equal to rk completes at once without going busy.
          done_d = (tgt_in == rk_q);
        end else if (tgt_q > rk_q) begin
          state_d = ST_RAMP_UP;
        end else if (tgt_q < rk_q) begin
          state_d = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_UP, ST_RAMP_DOWN: begin
        if (tgt_q == rk_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tgt_q > rk_q) begin
          state_d = ST_RAMP_UP;
        end else begin
          state_d = ST_RAMP_DOWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, target, setpoint and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rk_q    <= rk_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign rk   = rk_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
